// File: rtl/alu_input_sequencer_if.sv
// Switch/button inputs, ALU ports and display word of the ALU board-test front end.
// No handshake: every signal is a plain level, sampled or driven each core cycle.
interface alu_input_sequencer_if;
   logic [16:0] sw_data;
   logic [1:0]  key_n;
   logic [31:0] alu_result;
   logic [2:0]  alu_flags;
   logic [31:0] port_a;
   logic [31:0] port_b;
   logic [3:0]  alu_op;
   logic [31:0] disp_word;
   logic [2:0]  result_flags;
   logic        result_valid;
   logic [2:0]  state_o;

   modport master (
      output sw_data, key_n, alu_result, alu_flags,
      input  port_a, port_b, alu_op, disp_word, result_flags, result_valid, state_o
   );

   modport slave (
      input  sw_data, key_n, alu_result, alu_flags,
      output port_a, port_b, alu_op, disp_word, result_flags, result_valid, state_o
   );
endinterface

// File: rtl/alu_input_sequencer.sv
// Debounced ENTER/CLEAR walk through operand A, operand B and opcode; result captured after one EXECUTE cycle.
// Key press to action: DEBOUNCE_CYCLES+3 cycles; no backpressure, presses during EXECUTE are dropped.
module alu_input_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic                   CLOCK_50,
   input logic                   RESET,
   alu_input_sequencer_if.slave  bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      ENTER_A  = 3'd0,
      ENTER_B  = 3'd1,
      ENTER_OP = 3'd2,
      EXECUTE  = 3'd3,
      SHOW     = 3'd4
   } state_t;

   logic [1:0]         sync1, sync2, stable, stable_d, press;
   logic [1:0][CW-1:0] cnt;
   logic               enter, clear;
   logic [31:0]        sw_ext;

   state_t      state, state_next;
   logic [31:0] port_a, port_b, result_q;
   logic [3:0]  alu_op;
   logic [2:0]  result_flags;
   logic        result_valid;

   assign sw_ext = {{16{bus.sw_data[16]}}, bus.sw_data[15:0]};
   assign enter  = press[0];
   assign clear  = press[1];

   // Key [0] is ENTER, key [1] is CLEAR; both are active low, so a press is stable 1->0.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         sync1    <= 2'b11;
         sync2    <= 2'b11;
         stable   <= 2'b11;
         stable_d <= 2'b11;
         press    <= 2'b00;
         cnt      <= '0;
      end else begin
         sync1    <= bus.key_n;
         sync2    <= sync1;
         stable_d <= stable;
         press    <= stable_d & ~stable;
         for (int k = 0; k < 2; k++) begin
            if (sync2[k] == stable[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] == LAST) begin
               stable[k] <= sync2[k];
               cnt[k]    <= '0;
            end else begin
               cnt[k] <= cnt[k] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) state <= ENTER_A;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = ENTER_A;
      end else begin
         case (state)
            ENTER_A:  if (enter) state_next = ENTER_B;
            ENTER_B:  if (enter) state_next = ENTER_OP;
            ENTER_OP: if (enter) state_next = EXECUTE;
            EXECUTE:  state_next = SHOW;
            SHOW:     if (enter) state_next = ENTER_A;
            default:  state_next = ENTER_A;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET || clear) begin
         port_a       <= '0;
         port_b       <= '0;
         alu_op       <= '0;
         result_q     <= '0;
         result_flags <= '0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            ENTER_A:  if (enter) port_a <= sw_ext;
            ENTER_B:  if (enter) port_b <= sw_ext;
            ENTER_OP: if (enter) alu_op <= bus.sw_data[3:0];
            EXECUTE: begin
               result_q     <= bus.alu_result;
               result_flags <= bus.alu_flags;
            end
            default: ;
         endcase
         result_valid <= (state_next == SHOW);
      end
   end

   always_comb begin
      case (state)
         ENTER_A, ENTER_B: bus.disp_word = sw_ext;
         ENTER_OP:         bus.disp_word = {28'h0, bus.sw_data[3:0]};
         default:          bus.disp_word = result_q;
      endcase
   end

   assign bus.port_a       = port_a;
   assign bus.port_b       = port_b;
   assign bus.alu_op       = alu_op;
   assign bus.result_flags = result_flags;
   assign bus.result_valid = result_valid;
   assign bus.state_o      = state;
endmodule
